// File: rtl/ca5_sched_pkg.sv
// Shared definitions for the round-robin down-count scheduler.
// Holds the FSM state encoding and the default requester/count sizing.
package ca5_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/ca5_rr_sched_if.sv
// Requester and datapath signal bundle for ca5_rr_sched.
// slave is the scheduler's view, master is the environment's view.
interface ca5_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int CW   = 3
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] cnt_i;
  logic               dp_zero;
  logic               dp_ld;
  logic [CW-1:0]      dp_val;
  logic               dp_dn;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic               busy;
  logic [IW-1:0]      gnt_id;

  modport slave (
    input  req, cnt_i, dp_zero,
    output dp_ld, dp_val, dp_dn, ack, err, busy, gnt_id
  );

  modport master (
    output req, cnt_i, dp_zero,
    input  dp_ld, dp_val, dp_dn, ack, err, busy, gnt_id
  );
endinterface

// File: rtl/ca5_rr_pick.sv
// Combinational round-robin picker: first set request found searching
// upward from ptr+1, wrapping modulo NREQ.
module ca5_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int k;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = NREQ; i >= 1; i--) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (req[k[IW-1:0]]) begin
        valid = 1'b1;
        idx   = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ca5_rr_sched.sv
// Round-robin scheduler granting a shared down-count datapath to NREQ
// requesters, with a watchdog that aborts a countdown that never reaches zero.
module ca5_rr_sched
  import ca5_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
) (
  input logic            clk,
  input logic            rst,
  ca5_rr_sched_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = CW + 2;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt;
  logic [CW-1:0]   val;
  logic [WW-1:0]   wdog;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [CW-1:0]   cnt_sel;
  logic            wd_hit;

  ca5_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    cnt_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == IW'(k)) cnt_sel = bus.cnt_i[k*CW +: CW];
    end
  end

  // Compare against the post-increment count so value+2 RUN cycles elapse before abort.
  assign wd_hit = (wdog + WW'(1)) == (WW'(val) + WW'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= IW'(NREQ - 1);
      gnt  <= '0;
      val  <= '0;
      wdog <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt <= pick_idx;
            val <= cnt_sel;
          end
        end
        LOAD:     wdog <= '0;
        RUN:      wdog <= wdog + WW'(1);
        DONE,
        ERR:      ptr  <= gnt;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    bus.dp_ld  = 1'b0;
    bus.dp_val = '0;
    bus.dp_dn  = 1'b0;
    bus.ack    = '0;
    bus.err    = 1'b0;
    bus.busy   = (state != IDLE);
    bus.gnt_id = gnt;
    case (state)
      IDLE: begin
        if (pick_vld) state_nx = LOAD;
      end
      LOAD: begin
        bus.dp_ld  = 1'b1;
        bus.dp_val = val;
        state_nx   = (val == '0) ? DONE : RUN;
      end
      RUN: begin
        bus.dp_dn = ~bus.dp_zero;
        if (bus.dp_zero)  state_nx = DONE;
        else if (wd_hit)  state_nx = ERR;
      end
      DONE: begin
        bus.ack  = NREQ'(1) << gnt;
        state_nx = IDLE;
      end
      ERR: begin
        bus.ack  = NREQ'(1) << gnt;
        bus.err  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ca5_rr_sched.sv
// Scoreboard bench for ca5_rr_sched: stimulus queues expected load/ack
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_ca5_rr_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ca5_rr_sched_if #(.NREQ(4), .CW(3)) bus();

  ca5_rr_sched #(.NREQ(4), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit       is_ack;
    bit [3:0] ack;
    bit       err;
    int       gnt;
    int       val;
    int       gap;
    int       lat;
    int       dn;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   ld_cyc     = 0;
  int   last_ack   = 0;
  int   dn_seen    = 0;
  bit   auto_drop  = 1'b0;
  bit   tie0       = 1'b0;
  logic [2:0] dcnt = 3'd0;

  // Datapath down-counter model
  always @(posedge clk) begin
    if (bus.dp_ld)                   dcnt <= bus.dp_val;
    else if (bus.dp_dn && dcnt != 0) dcnt <= dcnt - 3'd1;
  end
  assign bus.dp_zero = tie0 ? 1'b0 : (dcnt == 3'd0);

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] pack(input int c0, input int c1, input int c2, input int c3);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  task automatic push_ld(input int gnt, input int val, input int gap);
    exp_t e;
    e = '{is_ack: 1'b0, ack: 4'd0, err: 1'b0, gnt: gnt, val: val, gap: gap, lat: 0, dn: 0};
    q.push_back(e);
  endtask

  task automatic push_op(input int gnt, input int val, input int gap,
                         input int lat, input int dn, input bit err);
    exp_t e;
    push_ld(gnt, val, gap);
    e = '{is_ack: 1'b1, ack: 4'(1 << gnt), err: err, gnt: gnt, val: 0, gap: 0, lat: lat, dn: dn};
    q.push_back(e);
  endtask

  // Requesters that release their request once acknowledged
  always @(negedge clk) begin
    if (auto_drop && bus.ack != 4'd0) bus.req = bus.req & ~bus.ack;
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      chk("excl", int'(int'(bus.dp_ld) + int'(bus.dp_dn) + $countones(bus.ack) <= 1), 1);
      chk("err_wo_ack", int'(bus.err && bus.ack == 4'd0), 0);
      if (!bus.dp_ld) chk("dp_val_idle", int'(bus.dp_val), 0);
      if (bus.dp_dn) dn_seen++;
      if (bus.dp_ld) begin
        if (q.size() == 0) chk("unexpected_ld", int'(bus.gnt_id), -1);
        else begin
          e = q.pop_front();
          chk("ld_kind", int'(e.is_ack), 0);
          chk("ld_gnt", int'(bus.gnt_id), e.gnt);
          chk("ld_val", int'(bus.dp_val), e.val);
          if (e.gap >= 0) chk("grant_gap", cyc - last_ack, e.gap);
        end
        ld_cyc  = cyc;
        dn_seen = 0;
      end
      if (bus.ack != 4'd0) begin
        if (q.size() == 0) chk("unexpected_ack", int'(bus.ack), 0);
        else begin
          e = q.pop_front();
          chk("ack_kind", int'(e.is_ack), 1);
          chk("ack_val", int'(bus.ack), int'(e.ack));
          chk("ack_err", int'(bus.err), int'(e.err));
          chk("ack_gnt", int'(bus.gnt_id), e.gnt);
          chk("ld_to_ack", cyc - ld_cyc, e.lat);
          chk("dn_cycles", dn_seen, e.dn);
        end
        last_ack = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic wait_ld(input int bound);
    int n = 0;
    @(negedge clk);
    while (!bus.dp_ld && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!bus.dp_ld) chk("ld_timeout", 0, 1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},   int'(bus.busy),   0);
    chk({tag, "_ack"},    int'(bus.ack),    0);
    chk({tag, "_err"},    int'(bus.err),    0);
    chk({tag, "_dp_ld"},  int'(bus.dp_ld),  0);
    chk({tag, "_dp_dn"},  int'(bus.dp_dn),  0);
    chk({tag, "_dp_val"}, int'(bus.dp_val), 0);
    chk({tag, "_gnt_id"}, int'(bus.gnt_id), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    bus.req   = 4'd0;
    bus.cnt_i = 12'd0;
    rst       = 1'b1;
    step(3);
    @(negedge clk);
    chk_outputs_zero("reset");
    step(1);
    rst = 1'b0;

    // Two requesters: 0 wins first, then 2 after one IDLE cycle
    auto_drop = 1'b1;
    bus.cnt_i = pack(3, 0, 1, 0);
    push_op(0, 3, -1, 5, 3, 1'b0);
    push_op(2, 1, 2, 3, 1, 1'b0);
    bus.req = 4'b0101;
    wait_empty(60);
    step(3);

    // Fresh reset, all requesters held: strict rotation 0,1,2,3,0
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    auto_drop = 1'b0;
    bus.cnt_i = pack(1, 0, 2, 1);
    push_op(0, 1, -1, 3, 1, 1'b0);
    push_op(1, 0, 2, 1, 0, 1'b0);
    push_op(2, 2, 2, 4, 2, 1'b0);
    push_op(3, 1, 2, 3, 1, 1'b0);
    push_op(0, 1, 2, 3, 1, 1'b0);
    bus.req = 4'b1111;
    wait_empty(100);
    bus.req = 4'b0000;
    step(4);

    // Zero count: LOAD straight to DONE
    auto_drop = 1'b1;
    bus.cnt_i = pack(5, 5, 0, 5);
    push_op(2, 0, -1, 1, 0, 1'b0);
    bus.req = 4'b0100;
    wait_empty(30);
    step(3);

    // Stuck datapath: watchdog abort after 7 RUN cycles
    tie0 = 1'b1;
    bus.cnt_i = pack(0, 5, 0, 0);
    push_op(1, 5, -1, 8, 7, 1'b1);
    bus.req = 4'b0010;
    wait_empty(40);
    tie0 = 1'b0;
    step(3);

    // Owner drops req and cnt_i changes mid-run: operation unaffected
    bus.cnt_i = pack(4, 0, 0, 0);
    push_op(0, 4, -1, 6, 4, 1'b0);
    bus.req = 4'b0001;
    wait_ld(20);
    step(2);
    bus.req   = 4'b0000;
    bus.cnt_i = pack(7, 7, 7, 7);
    wait_empty(40);
    step(3);

    // Reset during RUN of requester 3, request still pending afterwards
    bus.cnt_i = pack(0, 0, 0, 6);
    push_ld(3, 6, -1);
    bus.req = 4'b1000;
    wait_ld(20);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_outputs_zero("midrun_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    chk("req_kept", int'(bus.req), 8);
    push_op(3, 6, -1, 8, 6, 1'b0);
    wait_empty(60);
    step(5);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ca5_rr_sched.md
CA5_RR_SCHED -- requirements
Module: ca5_rr_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the down-count datapath.
REQ-002 Parameter CW, default 3, width of the count value n.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  NREQ  per-requester request level; held until its ack.
REQ-006 cnt_i  input  NREQ*CW  packed count values; requester k occupies bits [k*CW +: CW].
REQ-007 dp_zero  input  1  datapath down-counter has reached zero.
REQ-008 dp_ld  output  1  one-cycle load strobe to the datapath.
REQ-009 dp_val  output  CW  value presented with dp_ld; zero when dp_ld is low.
REQ-010 dp_dn  output  1  datapath down-count enable.
REQ-011 ack  output  NREQ  one-hot, one-cycle completion pulse to the owning requester.
REQ-012 err  output  1  one-cycle pulse on watchdog abort, coincident with ack.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 gnt_id  output  clog2(NREQ)  index of the current owner; holds its last value in IDLE.

Function
REQ-015 The FSM shall have the states IDLE, LOAD, RUN, DONE and ERR.
REQ-016 In IDLE with req nonzero, the block shall pick the winner by searching upward from ptr+1 modulo NREQ, register gnt_id and its CW-bit value, and enter LOAD on the next edge.
REQ-017 In IDLE with req zero, the FSM shall remain in IDLE.
REQ-018 In LOAD, dp_ld shall be 1 and dp_val shall equal the latched value for exactly one cycle.
REQ-019 From LOAD, the FSM shall go to DONE if the latched value is 0, else to RUN.
REQ-020 In RUN, dp_dn shall equal NOT dp_zero, and a watchdog counter of width CW+2, cleared in LOAD, shall increment every RUN cycle.
REQ-021 RUN shall go to DONE in the cycle dp_zero is sampled 1.
REQ-022 RUN shall go to ERR when the watchdog equals value+2 with dp_zero still 0.
REQ-023 dp_zero has priority over the watchdog when both conditions hold in the same cycle.
REQ-024 DONE shall drive ack[gnt_id]=1 for one cycle, set ptr to gnt_id and return to IDLE.
REQ-025 ERR shall drive ack[gnt_id]=1 and err=1 for one cycle, set ptr to gnt_id and return to IDLE.
REQ-026 Latency from req sampled in IDLE to dp_ld shall be 1 cycle; back-to-back grants shall be separated by one IDLE cycle.
REQ-027 Deassertion of the owner's req, or any change of cnt_i, after the grant shall not alter the operation in progress; ack is still issued.
REQ-028 Requests from non-owners during an operation shall be ignored until IDLE.
REQ-029 dp_ld, dp_dn, ack and err shall be mutually exclusive except ack with err.

Reset
REQ-030 Reset shall force the state to IDLE, ptr to NREQ-1 (index 0 wins first), gnt_id to 0, the watchdog and latched value to 0, and all outputs to 0.
REQ-031 Reset asserted mid-operation shall abort immediately with no ack and no err, and the first post-reset grant shall follow REQ-030 priority.

Structure
REQ-032 The state enumeration and the NREQ/CW defaults shall reside in the shared package ca5_sched_pkg.
REQ-033 The round-robin search shall be implemented in the combinational sub-module ca5_rr_pick (inputs req and ptr; outputs valid and idx).

Verification
REQ-034 After reset, req=4'b0101, cnt0=3, with dp_zero modelled by a real down-counter -> dp_ld with dp_val=3, dp_dn for 3 cycles, then ack=4'b0001 and gnt_id=0.
REQ-035 req=4'b1111 held continuously -> grant order 0,1,2,3,0 with one IDLE cycle between operations.
REQ-036 cnt2=0, only req[2] set -> LOAD then DONE, no dp_dn cycle, ack[2] two cycles after req is sampled.
REQ-037 cnt1=5 with dp_zero tied to 0 -> 7 RUN cycles, then err=1 and ack[1]=1 in the same cycle.
REQ-038 rst pulsed during RUN of requester 3 -> all outputs 0 immediately, no ack; with req=4'b1000 still set, the next grant goes to 3.
REQ-039 Owner req dropped and cnt_i changed during RUN -> countdown completes unchanged and ack is still pulsed.
